serial_frame_tx: RTL and testbench
==================================

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per frame (legal 5..16).
REQ-002 Parameter STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 areset  input  1  asynchronous reset, active-low (0 = reset asserted).
REQ-005 in_data  input  DATA_W  parallel payload, sampled only at acceptance.
REQ-006 in_valid  input  1  producer has a payload on in_data.
REQ-007 in_ready  output  1  block can accept a payload this cycle.
REQ-008 out  output  1  serial line, registered; idle level 1.
REQ-009 busy  output  1  high while any frame bit is being driven.
REQ-010 done  output  1  one-cycle pulse marking the final stop-bit cycle.

Function
REQ-011 The block SHALL use a registered FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-012 Acceptance SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_data SHALL be latched into a shift register on that edge.
REQ-013 in_ready SHALL be 1 in IDLE and in the final STOP cycle, and 0 in all other cycles.
REQ-014 After acceptance, out SHALL be 0 for exactly one cycle (START) on the cycle following the accepting edge.
REQ-015 DATA SHALL drive DATA_W cycles, LSB first, one bit per clock; a bit counter SHALL count 0..DATA_W-1 and then exit DATA.
REQ-016 PARITY, when compiled in, SHALL drive one cycle of odd parity: data ones plus the parity bit equals an odd count.
REQ-017 STOP SHALL drive out=1 for STOP_BITS cycles.
REQ-018 Frame length SHALL be 1+DATA_W+P+STOP_BITS cycles, where P=1 with parity and P=0 without.
REQ-019 Acceptance in the final STOP cycle SHALL go directly to START with no idle gap.
REQ-020 Without acceptance in the final STOP cycle, the FSM SHALL return to IDLE, with out=1.
REQ-021 busy SHALL be 1 in START/DATA/PARITY/STOP and 0 in IDLE.
REQ-022 done SHALL be 1 only during the final STOP cycle of each frame.
REQ-023 Changes on in_data or in_valid after acceptance SHALL have no effect on the frame in flight.
REQ-024 in_valid=1 in IDLE SHALL be accepted immediately; there is no minimum idle time.

Reset
REQ-025 While areset=0, the block SHALL set state=IDLE, out=1, busy=0, done=0, in_ready=1, and clear the shift register and bit counter, independent of clk.
REQ-026 Reset asserted mid-frame SHALL abort the frame; out SHALL return to 1 without waiting for a clock, and no done pulse SHALL be produced.
REQ-027 After areset deasserts, the first acceptance SHALL be possible on the next rising edge.

Configuration
REQ-028 Macro SERIAL_FRAME_TX_PARITY_EN: when defined, the PARITY state and parity generator SHALL be compiled in (P=1).
REQ-029 When SERIAL_FRAME_TX_PARITY_EN is undefined, the PARITY state SHALL not exist, and DATA SHALL transition directly to STOP (P=0).

Verification
REQ-030 No parity, DATA_W=8: accept 0xA5 -> out = 0,1,0,1,0,0,1,0,1,1 over 10 cycles; done high in cycle 10 only; then out=1 and in_ready=1.
REQ-031 Parity enabled: accept 0xA5 -> parity bit 1, 11-cycle frame; accept 0x01 -> parity bit 0; accept 0x00 -> parity bit 1.
REQ-032 Back-to-back, no parity: hold in_valid=1 with 0x55 then 0x0F -> 20 consecutive frame cycles with no out=1 idle gap between frames; exactly two done pulses.
REQ-033 Mid-frame reset: during the 4th data bit, drive areset=0 between clock edges -> out=1, busy=0, in_ready=1 immediately; no done pulse; a following 0x3C frame is transmitted correctly.
REQ-034 STOP_BITS=2, no parity: accept 0xFF -> out = 0, eight 1s, 1,1; 11-cycle frame; in_ready=1 only in the second stop cycle.
REQ-035 Data hold: change in_data from 0x81 to 0x7E one cycle after acceptance -> out still carries 0x81 (1,0,0,0,0,0,0,1).

Source files
------------

// File: rtl/serial_frame_tx_if.sv
// Handshake and serial-line bundle for serial_frame_tx.
//   in_data  : parallel payload, producer -> transmitter
//   in_valid : producer has a payload on in_data
//   in_ready : transmitter can accept a payload this cycle
//   out      : serial line, idle high
//   busy     : a frame bit is being driven
//   done     : one-cycle pulse on the final stop-bit cycle
// master = producer side, slave = transmitter side.
interface serial_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              out;
  logic              busy;
  logic              done;

  modport master (
    output in_data, in_valid,
    input  in_ready, out, busy, done
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out, busy, done
  );
endinterface

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial frame transmitter.
// Frame = start bit (0), DATA_W payload bits LSB first, optional odd parity
// bit, STOP_BITS stop bits (1). Line idles high. A new payload accepted in
// the final stop cycle starts the next frame with no idle gap.
//
// Optional feature: define SERIAL_FRAME_TX_PARITY_EN to add the PARITY state
// and odd-parity generator.
//
// Ports:
//   clk    : clock, rising edge
//   areset : asynchronous reset, active-low
//   bus    : serial_frame_tx_if slave modport (in_data/in_valid/in_ready,
//            out/busy/done)
module serial_frame_tx #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input logic               clk,
  input logic               areset,
  serial_frame_tx_if.slave  bus
);

  localparam int              CNT_W      = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic            LAST_STOP  = 1'(STOP_BITS - 1);
  // With a single stop bit the first stop cycle is already the final one.
  localparam logic            ONE_STOP   = (STOP_BITS == 1);

`ifdef SERIAL_FRAME_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              stop_cnt_q;
  logic              out_q;
  logic              busy_q;
  logic              done_q;
  logic              ready_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic              parity_q;
`endif
  logic              accept;

  assign accept       = bus.in_valid & ready_q;
  assign bus.in_ready = ready_q;
  assign bus.out      = out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  // Outputs are registered alongside the state: every transition also loads
  // the output values that belong to the state being entered.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      stop_cnt_q <= 1'b0;
      out_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q <= bus.in_data;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            // Odd parity: bit is 1 when the payload has an even count of ones.
            parity_q <= ~^bus.in_data;
`endif
            state_q <= START;
            out_q   <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end

        START: begin
          state_q <= DATA;
          cnt_q   <= '0;
          out_q   <= shift_q[0];
          shift_q <= shift_q >> 1;
        end

        DATA: begin
          if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
            state_q <= PARITY;
            out_q   <= parity_q;
`else
            state_q    <= STOP;
            out_q      <= 1'b1;
            stop_cnt_q <= 1'b0;
            done_q     <= ONE_STOP;
            ready_q    <= ONE_STOP;
`endif
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            out_q   <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end

`ifdef SERIAL_FRAME_TX_PARITY_EN
        PARITY: begin
          state_q    <= STOP;
          out_q      <= 1'b1;
          stop_cnt_q <= 1'b0;
          done_q     <= ONE_STOP;
          ready_q    <= ONE_STOP;
        end
`endif

        STOP: begin
          if (stop_cnt_q == LAST_STOP) begin
            // Final stop cycle: chain straight into the next frame if offered.
            if (accept) begin
              shift_q <= bus.in_data;
`ifdef SERIAL_FRAME_TX_PARITY_EN
              parity_q <= ~^bus.in_data;
`endif
              state_q <= START;
              out_q   <= 1'b0;
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              state_q <= IDLE;
              out_q   <= 1'b1;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end
          end else begin
            stop_cnt_q <= stop_cnt_q + 1'b1;
            done_q     <= 1'b1;
            ready_q    <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          out_q   <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: one instance with one stop bit and one
// with two stop bits, both 8-bit payload.
module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk;
  logic areset;
  int   errors;
  int   checks;
  int   done_seen;

  serial_frame_tx_if #(.DATA_W(8)) bus_a ();
  serial_frame_tx_if #(.DATA_W(8)) bus_b ();

  serial_frame_tx #(.DATA_W(8), .STOP_BITS(1)) dut_a (
    .clk    (clk),
    .areset (areset),
    .bus    (bus_a)
  );

  serial_frame_tx #(.DATA_W(8), .STOP_BITS(2)) dut_b (
    .clk    (clk),
    .areset (areset),
    .bus    (bus_b)
  );

  logic [3:0] obs_a;
  logic [3:0] obs_b;
  assign obs_a = {bus_a.out, bus_a.busy, bus_a.done, bus_a.in_ready};
  assign obs_b = {bus_b.out, bus_b.busy, bus_b.done, bus_b.in_ready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
  endtask

  task automatic chk_idle(input bit sel, input string name);
    logic [3:0] o;
    o = sel ? obs_b : obs_a;
    chk({name, " idle out"},   o[3], 1'b1);
    chk({name, " idle busy"},  o[2], 1'b0);
    chk({name, " idle done"},  o[1], 1'b0);
    chk({name, " idle ready"}, o[0], 1'b1);
  endtask

  // Called with the frame already accepted (DUT in its start-bit cycle).
  // nv/nd are driven right after acceptance: either junk to prove the frame
  // is unaffected, or the next payload for a back-to-back frame.
  task automatic check_frame(input bit sel, input logic [7:0] d, input int stops,
                             input bit nv, input logic [7:0] nd, input string name);
    int         flen;
    logic [3:0] o;
    logic       eb;
    flen = 1 + 8 + P + stops;
    for (int i = 0; i < flen; i++) begin
      if (i == 0) begin
        if (sel) begin
          bus_b.in_valid = nv;
          bus_b.in_data  = nd;
        end else begin
          bus_a.in_valid = nv;
          bus_a.in_data  = nd;
        end
      end
      o = sel ? obs_b : obs_a;
      if (i == 0)                eb = 1'b0;
      else if (i <= 8)           eb = d[i-1];
      else if (P == 1 && i == 9) eb = ~^d;
      else                       eb = 1'b1;
      chk($sformatf("%s out c%0d", name, i),   o[3], eb);
      chk($sformatf("%s busy c%0d", name, i),  o[2], 1'b1);
      chk($sformatf("%s done c%0d", name, i),  o[1], (i == flen - 1));
      chk($sformatf("%s ready c%0d", name, i), o[0], (i == flen - 1));
      if (o[1]) done_seen++;
      tick();
    end
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    done_seen      = 0;
    areset         = 1'b1;
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = 8'h00;
    bus_b.in_valid = 1'b0;
    bus_b.in_data  = 8'h00;

    // Reset values, no clock edge yet.
    #1 areset = 1'b0;
    #1;
    chk_idle(0, "rst_a");
    chk_idle(1, "rst_b");
    #1 areset = 1'b1;
    tick();
    chk_idle(0, "post_rst");

    // 0xA5 -> 0,1,0,1,0,0,1,0,1,(parity),1
    bus_a.in_data  = 8'hA5;
    bus_a.in_valid = 1'b1;
    tick();
    done_seen = 0;
    check_frame(0, 8'hA5, 1, 1'b0, 8'h5A, "a5");
    chk("a5 done count", 16'(done_seen), 16'd1);
    chk_idle(0, "a5_end");

    // Parity boundary payloads (plain data frames when parity is absent).
    bus_a.in_data  = 8'h01;
    bus_a.in_valid = 1'b1;
    tick();
    check_frame(0, 8'h01, 1, 1'b0, 8'hFE, "p01");
    bus_a.in_data  = 8'h00;
    bus_a.in_valid = 1'b1;
    tick();
    check_frame(0, 8'h00, 1, 1'b0, 8'hFF, "p00");
    chk_idle(0, "p00_end");

    // Back-to-back 0x55 then 0x0F with in_valid held high.
    bus_a.in_data  = 8'h55;
    bus_a.in_valid = 1'b1;
    tick();
    done_seen = 0;
    check_frame(0, 8'h55, 1, 1'b1, 8'h0F, "b2b0");
    check_frame(0, 8'h0F, 1, 1'b0, 8'h00, "b2b1");
    chk("b2b done count", 16'(done_seen), 16'd2);
    chk_idle(0, "b2b_end");

    // Payload changed one cycle after acceptance must not leak in.
    bus_a.in_data  = 8'h81;
    bus_a.in_valid = 1'b1;
    tick();
    check_frame(0, 8'h81, 1, 1'b0, 8'h7E, "hold");
    chk_idle(0, "hold_end");

    // Mid-frame asynchronous reset during the 4th data bit.
    bus_a.in_data  = 8'hA5;
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid bit3 out", bus_a.out, 1'b0);
    chk("mid bit3 busy", bus_a.busy, 1'b1);
    #3 areset = 1'b0;
    #1;
    chk_idle(0, "mid_async");
    tick();
    areset = 1'b1;
    chk_idle(0, "mid_held");
    tick();
    chk_idle(0, "mid_after");
    bus_a.in_data  = 8'h3C;
    bus_a.in_valid = 1'b1;
    tick();
    done_seen = 0;
    check_frame(0, 8'h3C, 1, 1'b0, 8'hC3, "x3c");
    chk("x3c done count", 16'(done_seen), 16'd1);
    chk_idle(0, "x3c_end");

    // Two stop bits: ready only in the second stop cycle.
    bus_b.in_data  = 8'hFF;
    bus_b.in_valid = 1'b1;
    tick();
    check_frame(1, 8'hFF, 2, 1'b0, 8'h00, "sb2");
    chk_idle(1, "sb2_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
